// File: rtl/data_bus_seq_if.sv
// Bus-sequencer handshake bundle: core/DMA request side plus the data-mux
// control and strobe lines driven back by the sequencer.
interface data_bus_seq_if;
   logic       core_req;
   logic       core_wr;
   logic       core_src;
   logic       core_ack;
   logic       dma_req;
   logic       dma_wr;
   logic       dma_ack;
   logic       owner_dma;
   logic       DL_Control1;
   logic       DL_Control2;
   logic       DataOut;
   logic       RD;
   logic       WR;
   logic       dl_latch;
   logic       busy;
   logic [1:0] t_state;

   modport master (
      output core_req, core_wr, core_src, dma_req, dma_wr,
      input  core_ack, dma_ack, owner_dma, DL_Control1, DL_Control2,
             DataOut, RD, WR, dl_latch, busy, t_state
   );

   modport slave (
      input  core_req, core_wr, core_src, dma_req, dma_wr,
      output core_ack, dma_ack, owner_dma, DL_Control1, DL_Control2,
             DataOut, RD, WR, dl_latch, busy, t_state
   );
endinterface

// File: rtl/data_bus_seq.sv
// Data-bus transaction sequencer: arbitrates core vs DMA ownership and runs
// each transaction as a fixed T1..T4 cycle driving the DataMux controls.
//
// state | meaning
// IDLE  | no transaction; arbitrate on any request
// T1    | address phase; enables / RD asserted
// T2    | WR asserted for writes
// T3    | last strobe cycle; core read data captured
// T4    | ack to owner, enables dropped; arbitrate for back-to-back
module data_bus_seq #(
   parameter int MAX_DMA_RUN = 4,
   parameter int RUN_W       = 4
) (
   input logic           CLK,
   input logic           nRESET,
   data_bus_seq_if.slave bus
);

   typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_T3, S_T4} state_t;

   localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_DMA_RUN);

   state_t           state_q, state_d;
   logic             own_dma_q, own_dma_d;
   logic             wr_q, wr_d;
   logic             src_q, src_d;
   logic [RUN_W-1:0] run_q, run_d;

   logic       busy_q, busy_d;
   logic [1:0] tst_q, tst_d;
   logic       owner_q, owner_d;
   logic       dl1_q, dl1_d;
   logic       dl2_q, dl2_d;
   logic       dout_q, dout_d;
   logic       rd_q, rd_d;
   logic       wrs_q, wrs_d;
   logic       lat_q, lat_d;
   logic       cack_q, cack_d;
   logic       dack_q, dack_d;

   logic core_wins;
   logic t13, t23;

   always_comb begin
      state_d   = state_q;
      own_dma_d = own_dma_q;
      wr_d      = wr_q;
      src_d     = src_q;
      run_d     = run_q;
      core_wins = bus.core_req && (!bus.dma_req || (run_q == RUN_MAX));

      unique case (state_q)
         S_T1:    state_d = S_T2;
         S_T2:    state_d = S_T3;
         S_T3:    state_d = S_T4;
         default: begin
            if (bus.core_req || bus.dma_req) begin
               state_d = S_T1;
               if (core_wins) begin
                  own_dma_d = 1'b0;
                  wr_d      = bus.core_wr;
                  src_d     = bus.core_src;
                  run_d     = '0;
               end else begin
                  own_dma_d = 1'b1;
                  wr_d      = bus.dma_wr;
                  src_d     = 1'b0;
                  // Only a waiting core makes a DMA run count towards fairness
                  if (!bus.core_req)
                     run_d = '0;
                  else if (run_q != RUN_MAX)
                     run_d = run_q + RUN_W'(1);
               end
            end else begin
               state_d = S_IDLE;
            end
         end
      endcase

      // Outputs are registered, so they are decoded from the next state
      t13     = (state_d == S_T1) || (state_d == S_T2) || (state_d == S_T3);
      t23     = (state_d == S_T2) || (state_d == S_T3);
      busy_d  = (state_d != S_IDLE);
      tst_d   = 2'd0;
      unique case (state_d)
         S_T2:    tst_d = 2'd1;
         S_T3:    tst_d = 2'd2;
         S_T4:    tst_d = 2'd3;
         default: tst_d = 2'd0;
      endcase
      owner_d = busy_d && own_dma_d;
      dl1_d   = owner_d;
      dout_d  = t13 && !own_dma_d && wr_d && !src_d;
      dl2_d   = t13 && !own_dma_d && wr_d && src_d;
      rd_d    = t13 && !wr_d;
      wrs_d   = t23 && wr_d;
      lat_d   = (state_d == S_T3) && !own_dma_d && !wr_d;
      cack_d  = (state_d == S_T4) && !own_dma_d;
      dack_d  = (state_d == S_T4) && own_dma_d;
   end

   always_ff @(posedge CLK) begin
      if (!nRESET) begin
         state_q   <= S_IDLE;
         own_dma_q <= 1'b0;
         wr_q      <= 1'b0;
         src_q     <= 1'b0;
         run_q     <= '0;
         busy_q    <= 1'b0;
         tst_q     <= 2'd0;
         owner_q   <= 1'b0;
         dl1_q     <= 1'b0;
         dl2_q     <= 1'b0;
         dout_q    <= 1'b0;
         rd_q      <= 1'b0;
         wrs_q     <= 1'b0;
         lat_q     <= 1'b0;
         cack_q    <= 1'b0;
         dack_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         own_dma_q <= own_dma_d;
         wr_q      <= wr_d;
         src_q     <= src_d;
         run_q     <= run_d;
         busy_q    <= busy_d;
         tst_q     <= tst_d;
         owner_q   <= owner_d;
         dl1_q     <= dl1_d;
         dl2_q     <= dl2_d;
         dout_q    <= dout_d;
         rd_q      <= rd_d;
         wrs_q     <= wrs_d;
         lat_q     <= lat_d;
         cack_q    <= cack_d;
         dack_q    <= dack_d;
      end
   end

   assign bus.busy        = busy_q;
   assign bus.t_state     = tst_q;
   assign bus.owner_dma   = owner_q;
   assign bus.DL_Control1 = dl1_q;
   assign bus.DL_Control2 = dl2_q;
   assign bus.DataOut     = dout_q;
   assign bus.RD          = rd_q;
   assign bus.WR          = wrs_q;
   assign bus.dl_latch    = lat_q;
   assign bus.core_ack    = cack_q;
   assign bus.dma_ack     = dack_q;

   // Mux-contention and strobe exclusivity guards
   a_dv_res:  assert property (@(posedge CLK) !(dout_q && dl2_q));
   a_dis_en:  assert property (@(posedge CLK) !(dl1_q && (dout_q || dl2_q)));
   a_rd_wr:   assert property (@(posedge CLK) !(rd_q && wrs_q));
   a_ack_one: assert property (@(posedge CLK) !(cack_q && dack_q));

endmodule

// File: tb/tb_data_bus_seq.sv
// Scoreboard bench for data_bus_seq: stimulus queues hand-written T1..T4
// output traces, a negedge monitor captures each transaction and compares.
module tb_data_bus_seq;

   logic clk = 1'b0;
   logic nreset;
   always #5 clk = ~clk;

   data_bus_seq_if bus ();

   data_bus_seq #(.MAX_DMA_RUN(4), .RUN_W(4)) dut (
      .CLK    (clk),
      .nRESET (nreset),
      .bus    (bus)
   );

   // trace = {T1,T2,T3,T4}; each 10-bit word is
   // {busy, owner_dma, DL1, DL2, DataOut, RD, WR, dl_latch, core_ack, dma_ack}
   localparam logic [39:0] CW0 = {10'b1000100000, 10'b1000101000, 10'b1000101000, 10'b1000000010};
   localparam logic [39:0] CW1 = {10'b1001000000, 10'b1001001000, 10'b1001001000, 10'b1000000010};
   localparam logic [39:0] CRD = {10'b1000010000, 10'b1000010000, 10'b1000010100, 10'b1000000010};
   localparam logic [39:0] DWR = {10'b1110000000, 10'b1110001000, 10'b1110001000, 10'b1110000001};
   localparam logic [39:0] DRD = {10'b1110010000, 10'b1110010000, 10'b1110010000, 10'b1110000001};

   typedef struct {
      logic [39:0] tr;
      string       name;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;
   int   n_cack = 0;
   int   n_dack = 0;
   int   cyc = 0;
   int   last_cack_cyc = -100;
   int   cack_gap = 0;

   function automatic logic [9:0] obs();
      return {bus.busy, bus.owner_dma, bus.DL_Control1, bus.DL_Control2, bus.DataOut,
              bus.RD, bus.WR, bus.dl_latch, bus.core_ack, bus.dma_ack};
   endfunction

   task automatic push(input logic [39:0] tr, input string name);
      exp_t e;
      e.tr = tr;
      e.name = name;
      exp_q.push_back(e);
   endtask

   // Monitor
   logic [9:0] trc [4];
   int idx = 0;
   always @(negedge clk) begin
      exp_t e;
      cyc++;
      if (bus.core_ack) begin
         n_cack++;
         cack_gap = cyc - last_cack_cyc;
         last_cack_cyc = cyc;
      end
      if (bus.dma_ack) n_dack++;
      if (!bus.busy) begin
         idx = 0;
      end else begin
         total++;
         if (int'(bus.t_state) != idx) begin
            bad++;
            $display("FAIL t_state: got %0d want %0d at cycle %0d", bus.t_state, idx, cyc);
         end
         trc[bus.t_state] = obs();
         if (bus.t_state == 2'd3) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_txn: got %h want none", {trc[0], trc[1], trc[2], trc[3]});
            end else begin
               e = exp_q.pop_front();
               if ({trc[0], trc[1], trc[2], trc[3]} !== e.tr) begin
                  bad++;
                  $display("FAIL trace_%s: got %h want %h", e.name,
                           {trc[0], trc[1], trc[2], trc[3]}, e.tr);
               end
            end
            idx = 0;
         end else begin
            idx = int'(bus.t_state) + 1;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, got, want);
      end
   endtask

   task automatic wait_idle(input string name);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (!bus.busy) break;
      end
      check({name, "_idle"}, 32'(bus.busy), 32'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic hold(input bit core, input bit dma, input int n);
      bus.core_req = core;
      bus.dma_req  = dma;
      repeat (n) @(posedge clk);
      #1;
      bus.core_req = 1'b0;
      bus.dma_req  = 1'b0;
   endtask

   initial begin
      nreset       = 1'b0;
      bus.core_req = 1'b0;
      bus.core_wr  = 1'b0;
      bus.core_src = 1'b0;
      bus.dma_req  = 1'b0;
      bus.dma_wr   = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_outputs", 32'({obs(), bus.t_state}), 32'd0);
      @(posedge clk);
      #1;
      nreset = 1'b1;
      @(posedge clk);
      #1;

      // core write, DV source
      bus.core_wr = 1'b1; bus.core_src = 1'b0;
      push(CW0, "core_wr_dv");
      hold(1'b1, 1'b0, 1);
      wait_idle("core_wr_dv");

      // core read, src ignored
      bus.core_wr = 1'b0; bus.core_src = 1'b1;
      push(CRD, "core_rd");
      hold(1'b1, 1'b0, 1);
      wait_idle("core_rd");

      // back-to-back writes; src changes after the first grant
      bus.core_wr = 1'b1; bus.core_src = 1'b0;
      push(CW0, "b2b_first");
      push(CW1, "b2b_second");
      bus.core_req = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      bus.core_src = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      bus.core_req = 1'b0;
      wait_idle("b2b");
      check("b2b_ack_gap", 32'(cack_gap), 32'd4);

      // DMA-only write
      bus.dma_wr = 1'b1;
      push(DWR, "dma_wr");
      hold(1'b0, 1'b1, 1);
      wait_idle("dma_wr");

      // fairness: 4 DMA reads, 1 core write, repeated
      bus.dma_wr = 1'b0; bus.core_wr = 1'b1; bus.core_src = 1'b0;
      for (int r = 0; r < 2; r++) begin
         for (int k = 0; k < 4; k++) push(DRD, "fair_dma");
         push(CW0, "fair_core");
      end
      hold(1'b1, 1'b1, 40);
      wait_idle("fair");

      // reset during T2 of a core write
      bus.core_wr = 1'b1; bus.core_src = 1'b0;
      bus.core_req = 1'b1;
      @(posedge clk);
      #1;
      bus.core_req = 1'b0;
      @(posedge clk);
      #1;
      check("pre_reset_t2", 32'(bus.t_state), 32'd1);
      nreset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("abort_outputs", 32'({obs(), bus.t_state}), 32'd0);
      nreset = 1'b1;
      bus.core_wr = 1'b0;
      bus.core_req = 1'b1;
      push(CRD, "post_reset_rd");
      @(posedge clk);
      #1;
      bus.core_req = 1'b0;
      @(negedge clk);
      check("post_reset_t1", 32'({bus.busy, bus.t_state}), 32'({1'b1, 2'd0}));
      wait_idle("post_reset");

      check("core_ack_count", 32'(n_cack), 32'd7);
      check("dma_ack_count", 32'(n_dack), 32'd9);
      check("queue_empty", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: got running want finished");
      $fatal(1);
   end

endmodule

// File: doc/data_bus_seq.md
Name: data_bus_seq

Overview:
- Sequences external data-bus transactions through the per-bit data mux.
- Arbitrates bus ownership between the CPU core and a DMA requester.
- Drives the mux control lines: bus disable, ALU Res->DL, DV->DL, plus RD/WR strobes and a read-capture strobe.
- Sits between the decoder/DMA front-ends and the DataMux instance, and runs every transaction as a fixed 4-state cycle T1..T4.

Parameters:
- MAX_DMA_RUN, 4, number of consecutive DMA grants allowed while core_req is pending before the core must win (1..15).
- RUN_W, 4, width of the DMA run counter; must hold MAX_DMA_RUN.

Ports:
- CLK  in  1  CLK2 domain clock, rising edge.
- nRESET  in  1  synchronous reset, active-low.
- core_req  in  1  core requests a bus transaction.
- core_wr  in  1  core transaction is a write (0 = read); sampled at grant.
- core_src  in  1  core write data source: 0 = DV (DataOut), 1 = ALU Res (DL_Control2); sampled at grant.
- core_ack  out  1  one-cycle completion pulse for a core transaction.
- dma_req  in  1  DMA requests a bus transaction.
- dma_wr  in  1  DMA transaction is a write; sampled at grant.
- dma_ack  out  1  one-cycle completion pulse for a DMA transaction.
- owner_dma  out  1  1 while the current transaction belongs to DMA.
- DL_Control1  out  1  bus disable to the mux; 1 = core DL disconnected.
- DL_Control2  out  1  Res -> DL enable.
- DataOut  out  1  DV -> DL enable.
- RD  out  1  external read strobe.
- WR  out  1  external write strobe.
- dl_latch  out  1  one-cycle capture strobe for core read data on DL.
- busy  out  1  1 in any of T1..T4.
- t_state  out  2  0 = T1, 1 = T2, 2 = T3, 3 = T4; 0 when idle (qualify with busy).

Behaviour:
- Clock and reset: one clock, CLK; reset is synchronous and active-low via nRESET.
- States: IDLE, T1, T2, T3, T4. All outputs are registered.
- Reset (nRESET = 0 at a rising edge):
  - state = IDLE, run counter = 0.
  - Every output = 0 on the next edge.
  - Reset mid-transaction aborts it: no ack is issued and strobes drop immediately.
- Arbitration happens in IDLE or T4 when any req = 1:
  - DMA wins by default.
  - Core wins if core_req = 1 and dma_req = 0, or if core_req = 1 and run counter = MAX_DMA_RUN.
  - The winner's wr and src are latched and the next state is T1.
  - With no req, T4 -> IDLE and IDLE stays IDLE.
- Back-to-back: a req held high through the ack cycle is a new request. Continuous req gives a transaction every 4 cycles with no idle gap.
- Run counter:
  - Increments on each DMA grant while core_req = 1, saturating at MAX_DMA_RUN.
  - Clears on a core grant, or on any DMA grant made with core_req = 0.
- Core write, T1..T3:
  - DataOut = ~src, DL_Control2 = src.
  - WR = 1 during T2..T3.
  - Both enables drop in T4.
- Core read:
  - RD = 1 during T1..T3.
  - dl_latch = 1 in T3 only.
  - DataOut and DL_Control2 stay 0.
- DMA transaction:
  - DL_Control1 = 1 during T1..T4 and owner_dma = 1 during T1..T4.
  - DataOut, DL_Control2 and dl_latch stay 0.
  - RD/WR follow the same timing as core transactions per dma_wr.
- Ack: the owner's ack = 1 for exactly the T4 cycle.
- Invariants, checked by assertion:
  - DataOut & DL_Control2 = 0.
  - DL_Control1 & (DataOut | DL_Control2) = 0.
  - RD & WR = 0.
  - core_ack & dma_ack = 0.
- Input changes to wr/src after grant are ignored until the next grant.

Test Plan:
- Core write, src=0: core_req pulse for 1 cycle from IDLE -> DataOut=1 for 3 cycles (T1..T3), WR=1 for cycles 2-3, core_ack=1 on cycle 4, then IDLE with busy=0.
- Core read, src ignored: core_req for 1 cycle -> RD=1 for cycles 1-3, dl_latch=1 on cycle 3 only, core_ack on cycle 4; DataOut=DL_Control2=0 throughout.
- Core back-to-back write then write with core_src=1: hold core_req 8 cycles -> two transactions with no gap; the second asserts DL_Control2 (not DataOut) in T1..T3; two core_acks 4 cycles apart.
- Fairness with MAX_DMA_RUN=4: dma_req and core_req both held high -> 4 DMA transactions (DL_Control1=1, owner_dma=1), then 1 core transaction, then DMA resumes; pattern repeats every 5 transactions.
- Reset mid-operation: assert nRESET=0 during T2 of a core write -> next edge all outputs 0, no core_ack; after release with core_req=1 a fresh T1 starts one cycle later.
- DMA only, dma_wr=1: dma_req for 1 cycle -> WR=1 cycles 2-3, DL_Control1=1 cycles 1-4, dma_ack cycle 4, run counter stays 0 (core_req=0).
